uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_pkg.sv | 20 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common to rx and tx) and
// the bit-period helper used to derive baud timing from the clock rate.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      DONE   = 3'd5
   } uart_state_e;

   // Clock cycles per bit, truncated toward zero.
   function automatic int unsigned calc_period(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
      return clk_freq / baud_rate;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input; the reset value is
// a parameter so idle-high lines such as UART rx come out of reset idle.
module sync_2ff #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1-style framing with a ready/valid output holding register.
// Define UART_RX_PARITY_EN to add one even-parity bit after the data bits.
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned CLK_FREQ  = 50000000,
   parameter int unsigned BAUD_RATE = 9600,
   parameter int unsigned DATA_BITS = 8,
   parameter int unsigned STOP_BITS = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] data,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 parity_err
);

   localparam int unsigned PERIOD = calc_period(CLK_FREQ, BAUD_RATE);
   localparam int unsigned HALF   = PERIOD / 2;
   localparam int unsigned CNT_W  = $clog2(PERIOD) + 1;
   localparam int unsigned BIT_W  = $clog2(DATA_BITS + 2) + 1;

   logic                 rxs;
   uart_state_e          state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [BIT_W-1:0]     bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic                 frame_err_c;
   logic                 cnt_full_c;
   logic                 transfer_c;

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_bad_nxt;
   logic parity_err_c;
`endif

   sync_2ff #(
      .RST_VAL (1'b1)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (rx),
      .q   (rxs)
   );

   assign cnt_full_c = (cnt == CNT_W'(PERIOD - 1));
   assign transfer_c = data_valid & data_ready;

   // State, bit timing and shift register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shreg     <= shreg_nxt;
         frame_err <= frame_err_c;
`ifdef UART_RX_PARITY_EN
         par_bad    <= par_bad_nxt;
         parity_err <= parity_err_c;
`endif
      end
   end

   // Next-state, counter and sampling decisions.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      frame_err_c = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_nxt  = par_bad;
      parity_err_c = 1'b0;
`endif

      case (state)
         IDLE: begin
            cnt_nxt     = '0;
            bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
            par_bad_nxt = 1'b0;
`endif
            if (!rxs) begin
               state_nxt = START;
            end
         end

         // Re-check the start bit at its midpoint to reject short glitches.
         START: begin
            if (cnt == CNT_W'(HALF - 1)) begin
               cnt_nxt   = '0;
               state_nxt = rxs ? IDLE : DATA;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         DATA: begin
            if (cnt_full_c) begin
               cnt_nxt   = '0;
               shreg_nxt = DATA_BITS'({rxs, shreg} >> 1);
               if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
                  bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                  state_nxt = PARITY;
`else
                  state_nxt = STOP;
`endif
               end else begin
                  bit_idx_nxt = bit_idx + BIT_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

`ifdef UART_RX_PARITY_EN
         // Even parity: the parity bit equals the XOR of the data bits.
         PARITY: begin
            if (cnt_full_c) begin
               cnt_nxt   = '0;
               state_nxt = STOP;
               if (rxs != ^shreg) begin
                  parity_err_c = 1'b1;
                  par_bad_nxt  = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
`endif

         STOP: begin
            if (cnt_full_c) begin
               cnt_nxt = '0;
               if (!rxs) begin
                  frame_err_c = 1'b1;
                  state_nxt   = IDLE;
               end else if (bit_idx == BIT_W'(STOP_BITS - 1)) begin
                  bit_idx_nxt = '0;
`ifdef UART_RX_PARITY_EN
                  state_nxt = par_bad ? IDLE : DONE;
`else
                  state_nxt = DONE;
`endif
               end else begin
                  bit_idx_nxt = bit_idx + BIT_W'(1);
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end

         DONE: begin
            state_nxt = IDLE;
         end

         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output holding register; a new word beats a pending handshake drop.
   always_ff @(posedge clk) begin
      if (rst) begin
         data       <= '0;
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end else if (state == DONE) begin
         data       <= shreg;
         data_valid <= 1'b1;
         if (data_valid) begin
            overrun <= ~data_ready;
         end
      end else if (transfer_c) begin
         data_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

`ifndef UART_RX_PARITY_EN
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serialises frames from a bit-level model
// and checks word, latency and error pulses against expected frame outcomes.
module tb_uart_rx;

   localparam int unsigned CLK_FREQ  = 1000000;
   localparam int unsigned BAUD_RATE = 100000;
   localparam int unsigned DATA_BITS = 8;
   localparam int unsigned STOP_BITS = 1;
   localparam int unsigned PERIOD    = CLK_FREQ / BAUD_RATE;
   localparam int unsigned HALF      = PERIOD / 2;
`ifdef UART_RX_PARITY_EN
   localparam int unsigned PAR_BITS  = 1;
`else
   localparam int unsigned PAR_BITS  = 0;
`endif
   localparam int LAT = int'(3 + HALF + (DATA_BITS + STOP_BITS + PAR_BITS) * PERIOD);

   logic       clk;
   logic       rst;
   logic       rx;
   logic [7:0] data;
   logic       data_valid;
   logic       data_ready;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   logic [7:0] last_data = 8'h00;

   uart_rx #(
      .CLK_FREQ  (CLK_FREQ),
      .BAUD_RATE (BAUD_RATE),
      .DATA_BITS (DATA_BITS),
      .STOP_BITS (STOP_BITS)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .rx         (rx),
      .data       (data),
      .data_valid (data_valid),
      .data_ready (data_ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Event recorder, sampled on the falling edge.
   int         rise_cyc[$];
   logic [7:0] rise_dat[$];
   int   dv_hi   = 0;
   int   fe_hi   = 0;
   int   fe_rise = 0;
   int   pe_hi   = 0;
   logic dv_prev = 1'b0;
   logic fe_prev = 1'b0;

   always @(negedge clk) begin
      if (data_valid === 1'b1 && !dv_prev) begin
         rise_cyc.push_back(cyc);
         rise_dat.push_back(data);
      end
      if (data_valid === 1'b1) dv_hi <= dv_hi + 1;
      if (frame_err === 1'b1) fe_hi <= fe_hi + 1;
      if (frame_err === 1'b1 && !fe_prev) fe_rise <= fe_rise + 1;
      if (parity_err === 1'b1) pe_hi <= pe_hi + 1;
      dv_prev <= (data_valid === 1'b1);
      fe_prev <= (frame_err === 1'b1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (PERIOD) tick();
   endtask

   // Line model: start 0, data LSB first, optional even parity, stop bits.
   task automatic send_frame(input logic [7:0] d, input logic par_ok,
                             input logic stop_val, output int start);
      logic q[$];
      q.push_back(1'b0);
      for (int i = 0; i < int'(DATA_BITS); i++) q.push_back(d[i]);
      if (PAR_BITS != 0) q.push_back(par_ok ? ^d : ~^d);
      for (int i = 0; i < int'(STOP_BITS); i++) q.push_back(stop_val);
      start = cyc + 1;
      foreach (q[i]) drive_bit(q[i]);
      rx = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx = 1'b1; data_ready = 1'b0;
      repeat (3) tick();
      rst = 1'b0;
      tick();
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h want 00", data); end
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", data_valid); end
      checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", frame_err); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
      checks++; if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_parity_err got %b want 0", parity_err); end
      repeat (5) tick();
   endtask

   task automatic test_basic();
      int r0, dh0, fe0, st;
      data_ready = 1'b1;
      r0 = rise_cyc.size(); dh0 = dv_hi; fe0 = fe_hi;
      send_frame(8'hA5, 1'b1, 1'b1, st);
      repeat (10) tick();
      checks++;
      if (rise_cyc.size() != r0 + 1) begin
         errors++; $display("FAIL a5_rises got %0d want 1", rise_cyc.size() - r0);
      end else begin
         checks++; if (rise_cyc[r0] != st + LAT) begin errors++; $display("FAIL a5_latency got %0d want %0d", rise_cyc[r0] - st, LAT); end
         checks++; if (rise_dat[r0] !== 8'hA5) begin errors++; $display("FAIL a5_data got %h want a5", rise_dat[r0]); end
      end
      checks++; if (dv_hi - dh0 != 1) begin errors++; $display("FAIL a5_valid_width got %0d want 1", dv_hi - dh0); end
      checks++; if (fe_hi != fe0) begin errors++; $display("FAIL a5_frame_err got %0d want 0", fe_hi - fe0); end
      last_data = 8'hA5;
   endtask

   task automatic test_random();
      logic [7:0] d;
      logic stop_val, par_ok, exp_valid, exp_pe;
      int r0, fe0, pe0, st;
      data_ready = 1'b1;
      for (int n = 0; n < 8; n++) begin
         d        = 8'($urandom_range(0, 255));
         stop_val = ($urandom_range(0, 3) != 0);
         par_ok   = ($urandom_range(0, 3) != 0);
         exp_pe   = (PAR_BITS != 0) && !par_ok;
         exp_valid = stop_val && !exp_pe;
         r0 = rise_cyc.size(); fe0 = fe_rise; pe0 = pe_hi;
         send_frame(d, par_ok, stop_val, st);
         repeat ($urandom_range(5, 20)) tick();
         checks++;
         if (rise_cyc.size() - r0 != int'(exp_valid)) begin
            errors++; $display("FAIL rand%0d_rises got %0d want %0d", n, rise_cyc.size() - r0, exp_valid);
         end else if (exp_valid) begin
            checks++; if (rise_dat[r0] !== d) begin errors++; $display("FAIL rand%0d_data got %h want %h", n, rise_dat[r0], d); end
            checks++; if (rise_cyc[r0] != st + LAT) begin errors++; $display("FAIL rand%0d_latency got %0d want %0d", n, rise_cyc[r0] - st, LAT); end
         end
         checks++; if (fe_rise - fe0 != int'(!stop_val)) begin errors++; $display("FAIL rand%0d_frame_err got %0d want %0d", n, fe_rise - fe0, !stop_val); end
         checks++; if (pe_hi - pe0 != int'(exp_pe)) begin errors++; $display("FAIL rand%0d_parity_err got %0d want %0d", n, pe_hi - pe0, exp_pe); end
         if (exp_valid) last_data = d;
      end
      checks++; if (data !== last_data) begin errors++; $display("FAIL rand_hold got %h want %h", data, last_data); end
   endtask

   task automatic test_glitch();
      int r0, fe0, st;
      data_ready = 1'b1;
      r0 = rise_cyc.size(); fe0 = fe_hi;
      rx = 1'b0;
      repeat (3) tick();
      rx = 1'b1;
      repeat (20) tick();
      checks++; if (rise_cyc.size() != r0) begin errors++; $display("FAIL glitch_valid got %0d want 0", rise_cyc.size() - r0); end
      checks++; if (fe_hi != fe0) begin errors++; $display("FAIL glitch_frame_err got %0d want 0", fe_hi - fe0); end
      r0 = rise_cyc.size();
      send_frame(8'h3C, 1'b1, 1'b1, st);
      repeat (10) tick();
      checks++;
      if (rise_cyc.size() != r0 + 1) begin
         errors++; $display("FAIL glitch_3c_rises got %0d want 1", rise_cyc.size() - r0);
      end else begin
         checks++; if (rise_dat[r0] !== 8'h3C) begin errors++; $display("FAIL glitch_3c_data got %h want 3c", rise_dat[r0]); end
         checks++; if (rise_cyc[r0] != st + LAT) begin errors++; $display("FAIL glitch_3c_latency got %0d want %0d", rise_cyc[r0] - st, LAT); end
      end
      last_data = 8'h3C;
   endtask

   task automatic test_frame_err();
      int r0, fr0, fh0, st;
      data_ready = 1'b1;
      r0 = rise_cyc.size(); fr0 = fe_rise; fh0 = fe_hi;
      send_frame(8'h55, 1'b1, 1'b0, st);
      repeat (20) tick();
      checks++; if (fe_rise - fr0 != 1) begin errors++; $display("FAIL ferr_pulses got %0d want 1", fe_rise - fr0); end
      checks++; if (fe_hi - fh0 != 1) begin errors++; $display("FAIL ferr_width got %0d want 1", fe_hi - fh0); end
      checks++; if (rise_cyc.size() != r0) begin errors++; $display("FAIL ferr_valid got %0d want 0", rise_cyc.size() - r0); end
      checks++; if (data !== last_data) begin errors++; $display("FAIL ferr_data got %h want %h", data, last_data); end
   endtask

   task automatic test_back_to_back();
      int st;
      data_ready = 1'b0;
      send_frame(8'h11, 1'b1, 1'b1, st);
      checks++; if (data_valid !== 1'b1 || data !== 8'h11) begin errors++; $display("FAIL b2b_first got v=%b d=%h want v=1 d=11", data_valid, data); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_first_overrun got %b want 0", overrun); end
      send_frame(8'h22, 1'b1, 1'b1, st);
      repeat (5) tick();
      checks++; if (data !== 8'h22) begin errors++; $display("FAIL b2b_data got %h want 22", data); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL b2b_overrun got %b want 1", overrun); end
      checks++; if (data_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", data_valid); end
      data_ready = 1'b1;
      tick();
      data_ready = 1'b0;
      checks++; if (data_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain_valid got %b want 0", data_valid); end
      checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_drain_overrun got %b want 0", overrun); end
      repeat (5) tick();
      last_data = 8'h22;
   endtask

   task automatic test_reset_mid();
      int r0, fe0, pe0, st;
      data_ready = 1'b1;
      r0 = rise_cyc.size(); fe0 = fe_hi; pe0 = pe_hi;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(1'b1);
      rx = 1'b1;
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (PERIOD - 4) tick();
      for (int i = 5; i < int'(DATA_BITS + PAR_BITS + STOP_BITS); i++) drive_bit(1'b1);
      repeat (10) tick();
      checks++; if (rise_cyc.size() != r0) begin errors++; $display("FAIL rstmid_valid got %0d want 0", rise_cyc.size() - r0); end
      checks++; if (fe_hi != fe0) begin errors++; $display("FAIL rstmid_frame_err got %0d want 0", fe_hi - fe0); end
      checks++; if (pe_hi != pe0) begin errors++; $display("FAIL rstmid_parity_err got %0d want 0", pe_hi - pe0); end
      checks++; if (data !== 8'h00) begin errors++; $display("FAIL rstmid_data got %h want 00", data); end
      send_frame(8'h81, 1'b1, 1'b1, st);
      repeat (10) tick();
      checks++;
      if (rise_cyc.size() != r0 + 1) begin
         errors++; $display("FAIL rstmid_81_rises got %0d want 1", rise_cyc.size() - r0);
      end else begin
         checks++; if (rise_dat[r0] !== 8'h81) begin errors++; $display("FAIL rstmid_81_data got %h want 81", rise_dat[r0]); end
         checks++; if (rise_cyc[r0] != st + LAT) begin errors++; $display("FAIL rstmid_81_latency got %0d want %0d", rise_cyc[r0] - st, LAT); end
      end
      last_data = 8'h81;
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int r0, pe0, st;
      data_ready = 1'b1;
      r0 = rise_cyc.size(); pe0 = pe_hi;
      send_frame(8'h07, 1'b0, 1'b1, st);
      repeat (10) tick();
      checks++; if (pe_hi - pe0 != 1) begin errors++; $display("FAIL par_bad_pulse got %0d want 1", pe_hi - pe0); end
      checks++; if (rise_cyc.size() != r0) begin errors++; $display("FAIL par_bad_valid got %0d want 0", rise_cyc.size() - r0); end
      pe0 = pe_hi;
      send_frame(8'h07, 1'b1, 1'b1, st);
      repeat (10) tick();
      checks++; if (pe_hi != pe0) begin errors++; $display("FAIL par_ok_pulse got %0d want 0", pe_hi - pe0); end
      checks++; if (data !== 8'h07) begin errors++; $display("FAIL par_ok_data got %h want 07", data); end
      last_data = 8'h07;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_glitch();
      test_frame_err();
      test_random();
      test_back_to_back();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
